// File: rtl/switch_egress_scheduler.sv
// Round-robin egress scheduler: shares one egress port between NUM_PORTS ingress FIFOs,
// forwarding whole packets (length header, then payload) without interleaving.
module switch_egress_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PORTS-1:0]           i_fifo_empty,
  input  logic [NUM_PORTS*W_WIDTH-1:0]   i_fifo_data,
  output logic [NUM_PORTS-1:0]           o_fifo_rd_en,
  input  logic                           i_out_ready,
  output logic [W_WIDTH-1:0]             o_out_data,
  output logic                           o_out_valid,
  output logic                           o_out_sop,
  output logic                           o_out_eop,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic                           o_busy
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HEAD, LEN, PAY} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_last_grant;
  logic [IW-1:0]        r_pend_idx;
  logic [W_WIDTH-1:0]   r_remaining;
  logic                 r_pend;
  logic                 r_pend_last;
  logic [NUM_PORTS-1:0] r_grant;
  logic [W_WIDTH-1:0]   r_out_data;
  logic                 r_out_valid;
  logic                 r_out_sop;
  logic                 r_out_eop;

  logic                 w_hit;
  logic [IW-1:0]        w_next;
  logic                 w_rd;
  logic [W_WIDTH-1:0]   w_cur_data;
  logic [W_WIDTH-1:0]   w_pend_data;

  assign w_cur_data  = i_fifo_data[int'(r_gidx)*W_WIDTH +: W_WIDTH];
  assign w_pend_data = i_fifo_data[int'(r_pend_idx)*W_WIDTH +: W_WIDTH];

  // Walk the rotation backwards so the closest requester after last_grant wins.
  always_comb begin
    w_hit  = 1'b0;
    w_next = r_last_grant;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (!i_fifo_empty[(int'(r_last_grant) + k) % NUM_PORTS]) begin
        w_hit  = 1'b1;
        w_next = IW'((int'(r_last_grant) + k) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    w_rd         = 1'b0;
    o_fifo_rd_en = '0;
    case (r_state)
      HEAD:    w_rd = !i_fifo_empty[r_gidx] && i_out_ready;
      PAY:     w_rd = !i_fifo_empty[r_gidx] && i_out_ready && (r_remaining != '0);
      default: w_rd = 1'b0;
    endcase
    if (w_rd) o_fifo_rd_en[r_gidx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_gidx       <= '0;
      r_last_grant <= IW'(NUM_PORTS - 1);
      r_pend_idx   <= '0;
      r_remaining  <= '0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
      r_grant      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_pend      <= 1'b0;
      // A payload word read last cycle is now on the FIFO bus; its source index was latched.
      if (r_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pend_data;
        r_out_eop   <= r_pend_last;
      end
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_grant      <= ONE_HOT0 << w_next;
            r_gidx       <= w_next;
            r_last_grant <= w_next;
            r_state      <= HEAD;
          end
        end
        HEAD: begin
          if (w_rd) r_state <= LEN;
        end
        LEN: begin
          r_remaining <= w_cur_data;
          r_out_valid <= 1'b1;
          r_out_data  <= w_cur_data;
          r_out_sop   <= 1'b1;
          r_out_eop   <= (w_cur_data == '0);
          if (w_cur_data == '0) begin
            r_grant <= '0;
            r_state <= IDLE;
          end else begin
            r_state <= PAY;
          end
        end
        PAY: begin
          if (w_rd) begin
            r_remaining <= r_remaining - 1'b1;
            r_pend      <= 1'b1;
            r_pend_idx  <= r_gidx;
            r_pend_last <= (r_remaining == W_WIDTH'(1));
            if (r_remaining == W_WIDTH'(1)) begin
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_sop   = r_out_sop;
  assign o_out_eop   = r_out_eop;
  assign o_grant     = r_grant;
  assign o_busy      = (r_state != IDLE);

endmodule
